// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the reference clock: sequences the PLL reset, qualifies lock
// stability before releasing the core reset, and counts lock losses while running.
module pll_lock_supervisor #(
    parameter int LOCK_STABLE    = 1024,
    parameter int RELOCK_TIMEOUT = 50000,
    parameter int PLL_RST_LEN    = 16,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             loss_clr,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int MAX_AB  = (LOCK_STABLE > RELOCK_TIMEOUT) ? LOCK_STABLE : RELOCK_TIMEOUT;
    localparam int MAX_LEN = (MAX_AB > PLL_RST_LEN) ? MAX_AB : PLL_RST_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_LEN - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        ST_PLLRST    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          sync_1;
    logic          locked_s;
    logic          loss_event;
    logic          pll_rst_d;
    logic          sys_reset_d;
    logic          ready_d;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_1   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_1   <= pll_locked;
            locked_s <= sync_1;
        end
    end

    // State register; the shared counter restarts on every state change and idles in RUN
    always_ff @(posedge refclk) begin
        if (rst) begin
            cur_state <= ST_PLLRST;
            cnt       <= '0;
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state || cur_state == ST_RUN)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_PLLRST: begin
                if (cnt == RST_LAST)
                    next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s)
                    next_state = ST_STABLE;
                else if (cnt == TIMEOUT_LAST)
                    next_state = ST_PLLRST;
            end
            ST_STABLE: begin
                if (!locked_s)
                    next_state = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST)
                    next_state = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s)
                    next_state = ST_WAIT_LOCK;
            end
            default: next_state = ST_PLLRST;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with the state
    always_comb begin
        pll_rst_d   = (next_state == ST_PLLRST);
        sys_reset_d = (next_state != ST_RUN);
        ready_d     = (next_state == ST_RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            pll_rst   <= pll_rst_d;
            sys_reset <= sys_reset_d;
            ready     <= ready_d;
        end
    end

    assign loss_event = (cur_state == ST_RUN) && !locked_s;

    // A coincident clear is applied before the increment, leaving a count of one
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_count <= '0;
        end else if (loss_clr) begin
            loss_count <= loss_event ? CNT_W'(1) : '0;
        end else if (loss_event && loss_count != '1) begin
            loss_count <= loss_count + 1'b1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with LOCK_STABLE=8, RELOCK_TIMEOUT=20, PLL_RST_LEN=4.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       loss_clr;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] loss_count;
    logic [1:0] state;

    int tests;
    int fails;

    pll_lock_supervisor #(
        .LOCK_STABLE   (8),
        .RELOCK_TIMEOUT(20),
        .PLL_RST_LEN   (4),
        .CNT_W         (8)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .loss_clr  (loss_clr),
        .pll_rst   (pll_rst),
        .sys_reset (sys_reset),
        .ready     (ready),
        .loss_count(loss_count),
        .state     (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance n edges; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Reset for one edge with the given lock level, then release
    task automatic apply_reset(input logic lock);
        pll_locked = lock;
        loss_clr   = 1'b0;
        rst        = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // With lock held, RUN is reached 13 edges after reset release
    task automatic go_run();
        apply_reset(1'b1);
        tick(13);
    endtask

    // One short lock dropout from RUN; the loss registers 3 edges in, RUN again after 12
    task automatic lose_once();
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(11);
    endtask

    task automatic test_reset();
        pll_locked = 1'b0;
        loss_clr   = 1'b0;
        rst        = 1'b1;
        tick(2);
        tests++;
        if (pll_rst !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: pll_rst=%b sys_reset=%b ready=%b expected 1 1 0", pll_rst, sys_reset, ready);
        end
        tests++;
        if (loss_count !== 8'd0 || state !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: loss_count=%0d state=%0d expected 0 0", loss_count, state);
        end
        rst = 1'b0;
    endtask

    // No lock: PLL reset 4 cycles, WAIT_LOCK 20 cycles, repeating every 24
    task automatic test_timeout();
        logic exp_rst;
        apply_reset(1'b0);
        for (int k = 0; k <= 52; k++) begin
            exp_rst = ((k % 24) < 4);
            tests++;
            if (pll_rst !== exp_rst || state !== (exp_rst ? 2'd0 : 2'd1) || sys_reset !== 1'b1) begin
                fails++;
                $display("FAIL timeout_k%0d: pll_rst=%b state=%0d sys_reset=%b expected %b %0d 1",
                         k, pll_rst, state, sys_reset, exp_rst, exp_rst ? 0 : 1);
            end
            tick(1);
        end
    endtask

    task automatic test_lock_release();
        logic [1:0] exp_st;
        apply_reset(1'b1);
        for (int k = 0; k <= 15; k++) begin
            exp_st = (k < 4) ? 2'd0 : (k == 4) ? 2'd1 : (k < 13) ? 2'd2 : 2'd3;
            tests++;
            if (state !== exp_st || sys_reset !== (k < 13) || ready !== (k >= 13) || pll_rst !== (k < 4)) begin
                fails++;
                $display("FAIL release_k%0d: state=%0d sys_reset=%b ready=%b pll_rst=%b expected %0d %b %b %b",
                         k, state, sys_reset, ready, pll_rst, exp_st, k < 13, k >= 13, k < 4);
            end
            tick(1);
        end
    endtask

    task automatic test_glitch();
        apply_reset(1'b1);
        for (int k = 0; k <= 22; k++) begin
            if (k == 11) begin
                tests++;
                if (state !== 2'd2) begin
                    fails++;
                    $display("FAIL glitch_pending: state=%0d expected 2", state);
                end
            end
            if (k == 12) begin
                tests++;
                if (state !== 2'd1 || loss_count !== 8'd0) begin
                    fails++;
                    $display("FAIL glitch_drop: state=%0d loss=%0d expected 1 0", state, loss_count);
                end
            end
            if (k == 20) begin
                tests++;
                if (state !== 2'd2 || sys_reset !== 1'b1) begin
                    fail_glitch_requal: begin
                        fails++;
                        $display("FAIL glitch_requal: state=%0d sys_reset=%b expected 2 1", state, sys_reset);
                    end
                end
            end
            if (k == 21) begin
                tests++;
                if (state !== 2'd3 || ready !== 1'b1 || loss_count !== 8'd0) begin
                    fails++;
                    $display("FAIL glitch_run: state=%0d ready=%b loss=%0d expected 3 1 0", state, ready, loss_count);
                end
            end
            if (k == 9)  pll_locked = 1'b0;
            if (k == 10) pll_locked = 1'b1;
            tick(1);
        end
    endtask

    task automatic test_loss();
        go_run();
        pll_locked = 1'b0;
        for (int j = 0; j <= 16; j++) begin
            if (j == 2) begin
                tests++;
                if (sys_reset !== 1'b0 || state !== 2'd3 || loss_count !== 8'd0) begin
                    fails++;
                    $display("FAIL loss_early: sys_reset=%b state=%0d loss=%0d expected 0 3 0", sys_reset, state, loss_count);
                end
            end
            if (j == 3) begin
                tests++;
                if (sys_reset !== 1'b1 || ready !== 1'b0 || state !== 2'd1 || loss_count !== 8'd1) begin
                    fails++;
                    $display("FAIL loss_event: sys_reset=%b ready=%b state=%0d loss=%0d expected 1 0 1 1",
                             sys_reset, ready, state, loss_count);
                end
            end
            if (j == 8) begin
                tests++;
                if (state !== 2'd2) begin
                    fails++;
                    $display("FAIL loss_relock: state=%0d expected 2", state);
                end
            end
            if (j == 16) begin
                tests++;
                if (state !== 2'd3 || loss_count !== 8'd1) begin
                    fails++;
                    $display("FAIL loss_rerun: state=%0d loss=%0d expected 3 1", state, loss_count);
                end
            end
            tests++;
            if (pll_rst !== 1'b0) begin
                fails++;
                $display("FAIL loss_no_pllrst_j%0d: pll_rst=%b expected 0", j, pll_rst);
            end
            if (j == 5) pll_locked = 1'b1;
            tick(1);
        end
    endtask

    task automatic test_saturate();
        go_run();
        lose_once();
        tests++;
        if (loss_count !== 8'd1 || state !== 2'd3) begin
            fails++;
            $display("FAIL sat_first: loss=%0d state=%0d expected 1 3", loss_count, state);
        end
        for (int i = 0; i < 254; i++) lose_once();
        tests++;
        if (loss_count !== 8'd255) begin
            fails++;
            $display("FAIL sat_255: loss=%0d expected 255", loss_count);
        end
        lose_once();
        tests++;
        if (loss_count !== 8'd255 || state !== 2'd3) begin
            fails++;
            $display("FAIL sat_hold: loss=%0d state=%0d expected 255 3", loss_count, state);
        end
        // Clear lands on the same edge as the loss
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        loss_clr = 1'b1;
        tick(1);
        loss_clr = 1'b0;
        tests++;
        if (loss_count !== 8'd1 || state !== 2'd1) begin
            fails++;
            $display("FAIL sat_clr_coincident: loss=%0d state=%0d expected 1 1", loss_count, state);
        end
        tick(9);
        tests++;
        if (state !== 2'd3) begin
            fails++;
            $display("FAIL sat_back_to_run: state=%0d expected 3", state);
        end
        loss_clr = 1'b1;
        tick(1);
        loss_clr = 1'b0;
        tests++;
        if (loss_count !== 8'd0 || state !== 2'd3 || ready !== 1'b1) begin
            fails++;
            $display("FAIL clr_alone: loss=%0d state=%0d ready=%b expected 0 3 1", loss_count, state, ready);
        end
    endtask

    task automatic test_rst_in_run();
        go_run();
        lose_once();
        tests++;
        if (loss_count !== 8'd1 || state !== 2'd3) begin
            fails++;
            $display("FAIL rstrun_setup: loss=%0d state=%0d expected 1 3", loss_count, state);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++;
        if (pll_rst !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0 || loss_count !== 8'd0 || state !== 2'd0) begin
            fails++;
            $display("FAIL rstrun_immediate: pll_rst=%b sys_reset=%b ready=%b loss=%0d state=%0d expected 1 1 0 0 0",
                     pll_rst, sys_reset, ready, loss_count, state);
        end
        tick(3);
        tests++;
        if (pll_rst !== 1'b1 || state !== 2'd0) begin
            fails++;
            $display("FAIL rstrun_pllrst_len: pll_rst=%b state=%0d expected 1 0", pll_rst, state);
        end
        tick(1);
        tests++;
        if (pll_rst !== 1'b0 || state !== 2'd1) begin
            fails++;
            $display("FAIL rstrun_wait: pll_rst=%b state=%0d expected 0 1", pll_rst, state);
        end
        tick(9);
        tests++;
        if (state !== 2'd3 || sys_reset !== 1'b0) begin
            fails++;
            $display("FAIL rstrun_rerun: state=%0d sys_reset=%b expected 3 0", state, sys_reset);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        loss_clr   = 1'b0;
        test_reset();
        test_timeout();
        test_lock_release();
        test_glitch();
        test_loss();
        test_saturate();
        test_rst_in_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
